// File: rtl/clkdiv_bank.sv
// clkdiv_bank: a bank of NUM_CH 50%-duty clock dividers with
// glitch-free reconfiguration and a common phase-align pulse.
//
// Parameters:
//   NUM_CH   - number of divider channels (1..16)
//   CNT_W    - width of each half-period count
//   DEF_HALF - half-period loaded into every channel at reset
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   ch_en        - per-channel run enable
//   sync_restart - one-cycle pulse, phase-aligns all channels
//   cfg_valid    - configuration write request
//   cfg_ready    - configuration write may be accepted
//   cfg_ch       - target channel of the write
//   cfg_half     - new half-period value H
//   div_out      - divided clocks, period 2*(H+1)
//   div_tick     - one-cycle pulse on each div_out rise
module clkdiv_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] div_tick
);

  localparam logic [CNT_W-1:0] DEF_H =
    CNT_W'(DEF_HALF);

  // Per-channel state.
  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] tick_q;

  // Single-entry pending update.
  logic              pend_q;
  logic [3:0]        pend_ch_q;
  logic [CNT_W-1:0]  pend_half_q;

  logic              cfg_take;
  logic              cfg_hit;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;

  // A restart edge must not also accept a write, so the
  // handshake is closed combinationally during the pulse.
  assign cfg_ready = ~pend_q & ~sync_restart;
  assign cfg_take  = cfg_valid & cfg_ready;
  assign cfg_hit   = 32'(cfg_ch) < NUM_CH;

  assign div_out  = out_q;
  assign div_tick = tick_q;

  // The >= compare (not ==) keeps a channel from ever
  // running past a half-period that shrank under it.
  always_comb begin
    wrap  = '0;
    apply = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wrap[c] = ch_en[c] &
                (cnt_q[c] >= half_q[c]);
      apply[c] = pend_q &
                 (pend_ch_q == 4'(c)) &
                 (sync_restart | ~ch_en[c] |
                  wrap[c]);
    end
  end

  // Pending slot: filled by an in-range accepted write,
  // emptied the edge its value lands in half_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_half_q <= '0;
    end else if (|apply) begin
      pend_q <= 1'b0;
    end else if (cfg_take && cfg_hit) begin
      pend_q      <= 1'b1;
      pend_ch_q   <= cfg_ch;
      pend_half_q <= cfg_half;
    end
  end

  // Channel counters. The toggle that applies a new H was
  // decided by the old H; the new value governs the next
  // half-period only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        half_q[c] <= DEF_H;
        cnt_q[c]  <= '0;
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (apply[c])
          half_q[c] <= pend_half_q;
        if (sync_restart || !ch_en[c]) begin
          cnt_q[c]  <= '0;
          out_q[c]  <= 1'b0;
          tick_q[c] <= 1'b0;
        end else if (wrap[c]) begin
          cnt_q[c]  <= '0;
          out_q[c]  <= ~out_q[c];
          tick_q[c] <= ~out_q[c];
        end else begin
          cnt_q[c]  <= cnt_q[c] + CNT_W'(1);
          tick_q[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each half-period count.
REQ-003 The block SHALL have parameter DEF_HALF, default 0, meaning the half-period value loaded into every channel at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ch_en, input, NUM_CH bits: per-channel run enable.
REQ-007 The block SHALL have port sync_restart, input, 1 bit: a one-cycle pulse that phase-aligns all channels.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: the configuration write request.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: the configuration write may be accepted this cycle.
REQ-010 The block SHALL have port cfg_ch, input, 4 bits: the target channel index.
REQ-011 The block SHALL have port cfg_half, input, CNT_W bits: the new half-period value H.
REQ-012 The block SHALL have port div_out, output, NUM_CH bits: the divided clocks, registered.
REQ-013 The block SHALL have port div_tick, output, NUM_CH bits: a registered one-cycle pulse marking each div_out rising edge.

Function
REQ-014 Each channel SHALL hold a half-period register H and a CNT_W-bit counter cnt; div_out[c] SHALL have period 2*(H+1) clk cycles at a 50% duty cycle (H=0 gives divide-by-2).
REQ-015 While ch_en[c]=1, cnt SHALL increment each cycle; when cnt==H, cnt SHALL wrap to 0 and div_out[c] SHALL toggle on that edge.
REQ-016 div_tick[c] SHALL be 1 in exactly the cycles where div_out[c] has just transitioned 0->1, and 0 otherwise.
REQ-017 While ch_en[c]=0, cnt, div_out[c] and div_tick[c] SHALL be held at 0.
REQ-018 On re-enable, the first rising edge of div_out[c] SHALL occur H+1 edges after ch_en[c] is first sampled 1.
REQ-019 A configuration write SHALL be accepted on an edge where cfg_valid=1 and cfg_ready=1; the value SHALL be stored as pending for cfg_ch, and cfg_ready SHALL go 0 on the next cycle.
REQ-020 cfg_ready SHALL be 1 only when no update is pending, so at most one update is pending at a time.
REQ-021 A pending value SHALL be copied into H only at the target channel's next toggle edge (glitch-free), or immediately on the next edge if that channel is disabled; cfg_ready SHALL return to 1 on the cycle after the copy.
REQ-022 The toggle that applies the new H SHALL itself use the old H; the following half-period SHALL use the new H.
REQ-023 A write with cfg_ch >= NUM_CH SHALL be accepted and discarded, with cfg_ready staying 1.
REQ-024 On an edge where sync_restart=1, all cnt and div_out SHALL be cleared to 0, div_tick SHALL be 0, and any pending update SHALL be applied immediately; a cfg write in the same cycle SHALL not be accepted (cfg_ready is forced to 0 that cycle).
REQ-025 Priority SHALL be rst > sync_restart > cfg apply > normal counting.
REQ-026 If H changes to a value below the current cnt (only possible via sync_restart), counting SHALL restart from 0, so no channel ever counts past H.

Reset
REQ-027 While rst=1 at an edge: every H SHALL be set to DEF_HALF, cnt to 0, div_out to 0, div_tick to 0 and pending to empty; cfg_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 Reset asserted mid-period or with an update pending SHALL discard all state, with no residual toggle after release.
REQ-029 After rst deasserts with ch_en all 1, the first div_out rise SHALL be at edge DEF_HALF+1 on every channel, in phase across channels.

Verification
REQ-030 Reset with DEF_HALF=0 and ch_en=4'hF -> all div_out toggle every edge, rising at edge 1, with div_tick high on edges 1, 3, 5 and so on.
REQ-031 Write H=3 to channel 2 mid-period -> the current half-period completes at the old length, then div_out[2] has period 8 with 4 cycles high; cfg_ready is low from acceptance until the cycle after the toggle.
REQ-032 Back-to-back cfg_valid writes to channels 0 and 1 -> the second write stalls (cfg_ready=0) until channel 0 applies; both are then applied correctly.
REQ-033 Set H={0,1,2,3}, run 20 cycles, then pulse sync_restart -> all outputs are 0 the next cycle and re-rise at edges 1, 2, 3 and 4 after the pulse.
REQ-034 Write with cfg_ch=9 -> no H changes and cfg_ready stays 1; deasserting ch_en[1] with an update pending -> H applied next edge and div_out[1]=0.
REQ-035 Assert rst with a pending update at cnt=2 -> after release H=DEF_HALF, cfg_ready=1, and no toggle occurs before edge DEF_HALF+1.
